// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Purpose  : Shared constants and FSM encoding for the MEM-stage data memory.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam int          DM_DEPTH = 3072;
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam int          LANE_W   = 8;
    localparam int          LANE_N   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_t;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/dm_byte_merge.sv
`default_nettype none
// ============================================================================
// Module   : dm_byte_merge
// Purpose  : Combinational byte-lane merge of store data into an old word.
// Revision : 1.0 - initial release
// ============================================================================
module dm_byte_merge
    import mips_mem_pkg::*;
(
    input  logic [LANE_N*LANE_W-1:0] i_old_word,
    input  logic [LANE_N*LANE_W-1:0] i_wdata,
    input  logic [LANE_N-1:0]        i_be,
    output logic [LANE_N*LANE_W-1:0] o_new_word
);

    for (genvar g = 0; g < LANE_N; g++) begin : g_lane
        assign o_new_word[g*LANE_W +: LANE_W] = i_be[g] ? i_wdata[g*LANE_W +: LANE_W]
                                                        : i_old_word[g*LANE_W +: LANE_W];
    end

endmodule : dm_byte_merge
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Purpose  : Data-memory target with programmable latency, byte-enabled
//            stores, valid/ready response and a store write-trace port.
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH   = DM_DEPTH,
    parameter logic [31:0] BASE    = DM_BASE,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        trace_valid,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    localparam int                 c_idx_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = 4;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);
    localparam logic [32:0]        c_span     = 33'(DEPTH) * 33'd4;

    dm_state_t r_state, w_state_nx;

    logic               r_we;
    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nx;

    logic        r_req_ready,   w_req_ready_nx;
    logic        r_rsp_valid,   w_rsp_valid_nx;
    logic [31:0] r_rsp_rdata,   w_rsp_rdata_nx;
    logic        r_rsp_err,     w_rsp_err_nx;
    logic        r_trace_valid, w_trace_valid_nx;
    logic [31:0] r_trace_addr,  w_trace_addr_nx;
    logic [31:0] r_trace_data,  w_trace_data_nx;

    logic        w_accept;
    logic        w_mem_we;
    logic [32:0] w_off;
    logic        w_err;
    logic [c_idx_w-1:0] w_idx;
    logic [31:0] w_old;
    logic [31:0] w_merged;

    logic [31:0] r_mem [DEPTH];

    // 33-bit offset: bit 32 is the borrow, set when the address is below BASE
    assign w_off = {1'b0, r_addr} - {1'b0, BASE};
    assign w_err = (r_addr[1:0] != 2'b00) || w_off[32] || (w_off >= c_span);
    assign w_idx = w_off[c_idx_w+1:2];
    assign w_old = r_mem[w_idx];

    dm_byte_merge u_merge (
        .i_old_word (w_old),
        .i_wdata    (r_wdata),
        .i_be       (r_be),
        .o_new_word (w_merged)
    );

    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_accept         = 1'b0;
        w_mem_we         = 1'b0;
        w_req_ready_nx   = r_req_ready;
        w_rsp_valid_nx   = r_rsp_valid;
        w_rsp_rdata_nx   = r_rsp_rdata;
        w_rsp_err_nx     = r_rsp_err;
        w_trace_valid_nx = 1'b0;
        w_trace_addr_nx  = r_trace_addr;
        w_trace_data_nx  = r_trace_data;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept       = 1'b1;
                    w_cnt_nx       = c_cnt_init;
                    w_req_ready_nx = 1'b0;
                    w_state_nx     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_state_nx     = ST_RESP;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_err_nx   = w_err;
                    w_rsp_rdata_nx = (!w_err && !r_we) ? w_old : 32'h0;
                    // An all-zero byte enable is a silent no-op: no write, no trace
                    if (r_we && !w_err && (r_be != 4'b0000)) begin
                        w_mem_we         = 1'b1;
                        w_trace_valid_nx = 1'b1;
                        w_trace_addr_nx  = r_addr;
                        w_trace_data_nx  = w_merged;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nx     = ST_IDLE;
                    w_rsp_valid_nx = 1'b0;
                    w_req_ready_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx     = ST_IDLE;
                w_rsp_valid_nx = 1'b0;
                w_req_ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_trace_valid <= 1'b0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_req_ready   <= w_req_ready_nx;
            r_rsp_valid   <= w_rsp_valid_nx;
            r_rsp_rdata   <= w_rsp_rdata_nx;
            r_rsp_err     <= w_rsp_err_nx;
            r_trace_valid <= w_trace_valid_nx;
            r_trace_addr  <= w_trace_addr_nx;
            r_trace_data  <= w_trace_data_nx;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_be    <= req_be;
                r_wdata <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign trace_valid = r_trace_valid;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;

endmodule : dm_responder
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Purpose  : Scoreboard bench for dm_responder (LATENCY=1 and LATENCY=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b1;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic [3:0]  a_req_be = '0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_trace_valid;
    logic [31:0] a_rsp_rdata, a_trace_addr, a_trace_data;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b1;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_be = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_trace_valid;
    logic [31:0] b_rsp_rdata, b_trace_addr, b_trace_data;

    dm_responder #(.LATENCY(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_be(a_req_be), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .trace_valid(a_trace_valid), .trace_addr(a_trace_addr),
        .trace_data(a_trace_data)
    );

    dm_responder #(.LATENCY(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_be(b_req_be), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .trace_valid(b_trace_valid), .trace_addr(b_trace_addr),
        .trace_data(b_trace_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } trc_t;
    rsp_t        rsp_q[$];
    trc_t        trc_q[$];
    logic [31:0] model [int];
    int          a_acc_cyc = 0;
    int          b_acc_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor for DUT A: pops the scoreboard on every response handshake and trace pulse
    logic a_prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (a_rsp_valid && !a_prev_valid)
                chk("a_latency", 32'(cyc - a_acc_cyc), 32'd1);
            if (a_rsp_valid && a_rsp_ready) begin
                if (rsp_q.size() == 0) chk("a_rsp_unexpected", 32'(rsp_q.size()), 32'd1);
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("a_rdata", a_rsp_rdata, e.rdata);
                    chk("a_err", 32'(a_rsp_err), 32'(e.err));
                end
            end
            if (a_trace_valid) begin
                if (trc_q.size() == 0) chk("a_trace_unexpected", 32'(trc_q.size()), 32'd1);
                else begin
                    trc_t t;
                    t = trc_q.pop_front();
                    chk("a_trace_addr", a_trace_addr, t.addr);
                    chk("a_trace_data", a_trace_data, t.data);
                end
            end
        end
        a_prev_valid = a_rsp_valid;
    end

    task automatic issue_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] e_rd, input logic e_err,
                           input logic e_trc, input logic [31:0] e_td, input bit push);
        int n = 0;
        if (push) begin
            rsp_t r;
            r.rdata = e_rd;
            r.err   = e_err;
            rsp_q.push_back(r);
            if (e_trc) begin
                trc_t t;
                t.addr = {addr[31:2], 2'b00};
                t.data = e_td;
                trc_q.push_back(t);
                model[int'(addr[31:2])] = e_td;
            end
        end
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_be = be; a_req_wdata = wd;
        while (!a_req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!a_req_ready) chk("a_accept_timeout", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_acc_cyc   = cyc;
        a_req_valid = 1'b0;
    endtask

    function automatic void model_exp(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                      input logic [31:0] wd, output logic [31:0] rd,
                                      output logic err, output logic trc, output logic [31:0] td);
        logic [31:0] old;
        err = (addr[1:0] != 2'b00) || (addr >= 32'h3000);
        old = model.exists(int'(addr[31:2])) ? model[int'(addr[31:2])] : 32'h0;
        rd  = (!we && !err) ? old : 32'h0;
        trc = we && !err && (be != 4'b0000);
        td  = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) td[8*i +: 8] = wd[8*i +: 8];
    endfunction

    task automatic issue_b(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
        int n = 0;
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_be = be; b_req_wdata = wd;
        while (!b_req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!b_req_ready) chk("b_accept_timeout", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_acc_cyc = cyc;
        // Request lines are don't-care after acceptance; scramble them
        b_req_valid = 1'b0; b_req_we = ~we; b_req_addr = 32'h44; b_req_be = 4'hF;
        b_req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic wait_b_valid();
        int n = 0;
        while (!b_rsp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!b_rsp_valid) chk("b_valid_timeout", 32'(b_rsp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, td, ad, wd, hold;
        logic        er, tr, we;
        logic [3:0]  be;
        int          prev_acc, n;

        #6;
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
        chk("rst_trace_valid", 32'(a_trace_valid), 32'd0);
        chk("rst_trace_addr", a_trace_addr, 32'h0);
        chk("rst_trace_data", a_trace_data, 32'h0);
        chk("rst_b_req_ready", 32'(b_req_ready), 32'd1);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // we, addr, be, wdata, exp_rdata, exp_err, exp_trace, exp_trace_data
        issue_a(1, 32'h10,   4'hF,    32'hDEADBEEF, 32'h0,        0, 1, 32'hDEADBEEF, 1);
        issue_a(1, 32'h20,   4'hF,    32'h11223344, 32'h0,        0, 1, 32'h11223344, 1);
        issue_a(1, 32'h20,   4'b0101, 32'hAABBCCDD, 32'h0,        0, 1, 32'h11BB33DD, 1);
        issue_a(0, 32'h10,   4'h0,    32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        1);
        issue_a(0, 32'h20,   4'hF,    32'h0,        32'h11BB33DD, 0, 0, 32'h0,        1);
        issue_a(0, 32'h3000, 4'h0,    32'h0,        32'h0,        1, 0, 32'h0,        1);
        issue_a(1, 32'h2,    4'hF,    32'hFFFFFFFF, 32'h0,        1, 0, 32'h0,        1);
        issue_a(0, 32'h0,    4'h0,    32'h0,        32'h0,        0, 0, 32'h0,        1);
        issue_a(1, 32'h20,   4'b0000, 32'h12345678, 32'h0,        0, 0, 32'h0,        1);
        issue_a(0, 32'h20,   4'h0,    32'h0,        32'h11BB33DD, 0, 0, 32'h0,        1);
        issue_a(0, 32'h2FFC, 4'h0,    32'h0,        32'h0,        0, 0, 32'h0,        1);
        issue_a(1, 32'h2FFC, 4'b1000, 32'h0A0B0C0D, 32'h0,        0, 1, 32'h0A000000, 1);
        issue_a(0, 32'h2FFC, 4'h0,    32'h0,        32'h0A000000, 0, 0, 32'h0,        1);
        issue_a(0, 32'h10,   4'h0,    32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        1);

        // Reset in the middle of a store's WAIT phase
        issue_a(1, 32'h40, 4'hF, 32'h55667788, 32'h0, 0, 0, 32'h0, 0);
        #1 reset = 1'b1;
        #1;
        chk("arst_req_ready", 32'(a_req_ready), 32'd1);
        chk("arst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("arst_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("arst_trace_valid", 32'(a_trace_valid), 32'd0);
        chk("arst_trace_addr", a_trace_addr, 32'h0);
        chk("arst_trace_data", a_trace_data, 32'h0);
        #1 reset = 1'b0;
        model.delete();
        @(posedge clk); #1;
        issue_a(0, 32'h40, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
        issue_a(0, 32'h10, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1);

        // Back-to-back traffic against the reference model
        prev_acc = 0;
        for (int i = 0; i < 100; i++) begin
            n = int'($urandom_range(0, 9));
            if (n == 0)      ad = 32'h3000 + 32'($urandom_range(0, 3)) * 4;
            else if (n == 1) ad = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else             ad = 32'($urandom_range(0, 15)) << 2;
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            model_exp(we, ad, be, wd, rd, er, tr, td);
            issue_a(we, ad, be, wd, rd, er, tr, td, 1);
            if (i > 0) chk("b2b_spacing", 32'(a_acc_cyc - prev_acc), 32'd3);
            prev_acc = a_acc_cyc;
        end
        n = 0;
        while ((rsp_q.size() != 0 || trc_q.size() != 0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("trc_q_drained", 32'(trc_q.size()), 32'd0);

        // LATENCY=4 instance: latency, held payload and ready release
        b_rsp_ready = 1'b1;
        issue_b(1, 32'h30, 4'hF, 32'h12345678);
        wait_b_valid();
        chk("b_store_latency", 32'(cyc - b_acc_cyc), 32'd4);
        chk("b_store_err", 32'(b_rsp_err), 32'd0);
        chk("b_trace_valid", 32'(b_trace_valid), 32'd1);
        chk("b_trace_addr", b_trace_addr, 32'h30);
        chk("b_trace_data", b_trace_data, 32'h12345678);
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
        issue_b(0, 32'h30, 4'h0, 32'h0);
        wait_b_valid();
        chk("b_load_latency", 32'(cyc - b_acc_cyc), 32'd4);
        hold = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            chk("b_hold_valid", 32'(b_rsp_valid), 32'd1);
            chk("b_hold_rdata", b_rsp_rdata, hold);
            chk("b_hold_err", 32'(b_rsp_err), 32'd0);
            chk("b_hold_req_ready", 32'(b_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("b_hold_rdata_last", b_rsp_rdata, hold);
        chk("b_hold_req_ready_last", 32'(b_req_ready), 32'd0);
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("b_done_rsp_valid", 32'(b_rsp_valid), 32'd0);
        chk("b_done_req_ready", 32'(b_req_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dm_responder
`default_nettype wire

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory target on the CPU's MEM-stage bus; the CPU initiates, this block responds.
- Takes one load/store request at a time, holds it for a programmable latency, then completes it with a valid/ready response.
- Stores support byte enables. Every committed store is published on a write-trace port that benches use for golden-log comparison.
- Sits between the mips core and the system bus, replacing the single-cycle zero-wait DM.

Parameters:
- DEPTH, 3072: memory size in 32-bit words (12 KiB window).
- BASE, 32'h0000_0000: byte address of word 0.
- LATENCY, 1: edges from request acceptance to rsp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_be  input  4  byte-lane enables for stores; bit i selects wdata[8i+7:8i]; ignored on loads.
- req_wdata  input  32  store data, lane-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  CPU takes the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request faulted.
- trace_valid  output  1  one-cycle pulse per committed store.
- trace_addr  output  32  word-aligned byte address of that store.
- trace_data  output  32  full merged word after the store.

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-high; ports are named clk and reset.
- Reset values:
  - req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - trace_valid=0, trace_addr=0, trace_data=0.
  - FSM goes to IDLE; all memory words are cleared to 0.
  - Reset mid-transaction discards the pending request with no response and no trace.
- FSM states are IDLE, WAIT and RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch we/addr/be/wdata, load cnt=LATENCY-1, go to WAIT, and drop req_ready.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the access and go to RESP on this edge. rsp_valid rises at the same edge.
  - Net effect: a request accepted at edge k gives rsp_valid high after edge k+LATENCY.
- RESP:
  - rsp_valid and its payload stay stable until an edge with rsp_ready=1. On that edge go to IDLE, clear rsp_valid and raise req_ready.
  - Best-case throughput is one request per LATENCY+2 cycles. There is no request pipelining.
- Error check, evaluated on the latched request:
  - Error if addr[1:0]!=0, addr<BASE, or addr-BASE >= DEPTH*4 (compute in 33 bits so there is no wrap).
  - On error: rsp_err=1, rsp_rdata=0, memory untouched, no trace pulse.
- Load: rsp_rdata = the word at index (addr-BASE)>>2. The value includes every store committed earlier.
- Store:
  - For each i with be[i]=1, lane i of the new word is wdata lane i; other lanes keep the old word.
  - The merged word is written at the WAIT→RESP edge. trace_valid pulses for exactly that one cycle, with trace_addr/trace_data set.
  - be=4'b0000 is a legal no-op: no memory change, no trace, rsp_err=0.
- Request inputs outside an accepting IDLE edge are ignored. The CPU may change them freely while req_ready=0.
- Memory is inferred as a word array indexed by a $clog2(DEPTH)-bit index. Reset clearing is mandatory.

Decomposition:
- mips_mem_pkg holds:
  - FSM state encoding (IDLE/WAIT/RESP);
  - DM_BASE and DM_DEPTH defaults;
  - lane width and lane count constants.
- One sub-module, dm_byte_merge: a purely combinational merge of old word, wdata and be into the new word. It is reused by the future MMIO bridge.

Test Plan:
- Reset at 8 ns, LATENCY=1: store addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at edge k -> rsp_valid at k+1, err=0; trace pulse addr 0x10 data 0xDEADBEEF. Later load 0x10 -> rdata 0xDEADBEEF.
- Byte merge: word 0x20 holds 0x11223344; store be 4'b0101, wdata 0xAABBCCDD -> trace_data 0x11BB33DD; load returns 0x11BB33DD.
- Errors: load 0x3000 -> err=1, rdata=0; store 0x0000_0002 -> err=1, no trace, memory unchanged; store be=0 -> err=0, no trace.
- LATENCY=4 with rsp_ready held low for 3 cycles after rsp_valid -> rsp_valid rises exactly 4 edges after accept; payload stable while rsp_ready=0; req_ready stays 0 until the edge after the rsp_ready handshake.
- Reset pulse during WAIT of a store to 0x40 -> outputs return to reset values asynchronously; no trace; a later load of 0x40 returns 0.
- Back-to-back: 100 random requests with req_valid held high and rsp_ready=1, checked against a scoreboard model -> every rdata/err/trace matches; request spacing is exactly LATENCY+2 cycles.
